// File: rtl/pes_epb_desc_rx_if.sv
// pes_epb_desc_rx_if: EPB descriptor input, scheduler head and status bundle for pes_epb_desc_rx
interface pes_epb_desc_rx_if #(
  parameter int NUM_Q = 8,
  parameter int DEPTH = 16,
  parameter int LEN_W = 14,
  parameter int HDL_W = 20
);
  localparam int QW = $clog2(NUM_Q);
  localparam int BYTE_W = LEN_W + $clog2(DEPTH) + 1;
  logic epb_desc_valid;
  logic [QW-1:0] epb_desc_q;
  logic [LEN_W-1:0] epb_desc_len;
  logic [HDL_W-1:0] epb_desc_handle;
  logic pes_credit_rtn;
  logic sch_pop;
  logic head_valid;
  logic [QW-1:0] head_q;
  logic [LEN_W-1:0] head_len;
  logic [HDL_W-1:0] head_handle;
  logic [NUM_Q-1:0] q_nonempty;
  logic [BYTE_W-1:0] byte_occ;
  logic err_overflow;
  logic err_underflow;
  modport master (
    output epb_desc_valid, epb_desc_q, epb_desc_len, epb_desc_handle, sch_pop,
    input pes_credit_rtn, head_valid, head_q, head_len, head_handle, q_nonempty, byte_occ,
    err_overflow, err_underflow
  );
  modport slave (
    input epb_desc_valid, epb_desc_q, epb_desc_len, epb_desc_handle, sch_pop,
    output pes_credit_rtn, head_valid, head_q, head_len, head_handle, q_nonempty, byte_occ,
    err_overflow, err_underflow
  );
endinterface

// File: rtl/pes_epb_desc_rx.sv
// pes_epb_desc_rx: credit-flow-controlled EPB descriptor FIFO with per-queue and byte occupancy status
module pes_epb_desc_rx #(
  parameter int NUM_Q = 8,
  parameter int DEPTH = 16,
  parameter int LEN_W = 14,
  parameter int HDL_W = 20
) (
  input logic cclk,
  input logic rst_n,
  pes_epb_desc_rx_if.slave bus
);
  localparam int QW = $clog2(NUM_Q);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BYTE_W = LEN_W + AW + 1;
  localparam int DW = QW + LEN_W + HDL_W;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] occ, owed;
  logic [CW-1:0] cnt [NUM_Q];
  logic [CW-1:0] cnt_nx [NUM_Q];
  logic [NUM_Q-1:0] q_ne;
  logic [BYTE_W-1:0] bocc;
  logic credit, ovf, udf, hv, pop_ok, wr_ok, issue;
  logic [QW-1:0] hq;
  logic [LEN_W-1:0] hl;
  logic [HDL_W-1:0] hh;
  assign hv = occ != '0;
  assign {hq, hl, hh} = mem[rp];
  assign pop_ok = bus.sch_pop & hv;
  // a pop at full frees its slot for a write in the same cycle
  assign wr_ok = bus.epb_desc_valid & ((occ < CW'(DEPTH)) | pop_ok);
  assign issue = owed != '0;
  always_comb
    for (int i = 0; i < NUM_Q; i++)
      cnt_nx[i] = cnt[i] + CW'(wr_ok && bus.epb_desc_q == QW'(i)) - CW'(pop_ok && hq == QW'(i));
  always_ff @(posedge cclk)
    if (wr_ok) mem[wp] <= {bus.epb_desc_q, bus.epb_desc_len, bus.epb_desc_handle};
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      owed <= CW'(DEPTH);
      credit <= 1'b0;
      bocc <= '0;
      q_ne <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
      for (int i = 0; i < NUM_Q; i++) cnt[i] <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
      occ <= occ + CW'(wr_ok) - CW'(pop_ok);
      owed <= owed + CW'(pop_ok) - CW'(issue);
      credit <= issue;
      bocc <= bocc + (wr_ok ? BYTE_W'(bus.epb_desc_len) : '0) - (pop_ok ? BYTE_W'(hl) : '0);
      for (int i = 0; i < NUM_Q; i++) begin
        cnt[i] <= cnt_nx[i];
        q_ne[i] <= cnt_nx[i] != '0;
      end
      ovf <= ovf | (bus.epb_desc_valid & ~wr_ok);
      udf <= udf | (bus.sch_pop & ~hv);
    end
  end
  assign bus.pes_credit_rtn = credit;
  assign bus.head_valid = hv;
  assign bus.head_q = hq;
  assign bus.head_len = hl;
  assign bus.head_handle = hh;
  assign bus.q_nonempty = q_ne;
  assign bus.byte_occ = bocc;
  assign bus.err_overflow = ovf;
  assign bus.err_underflow = udf;
endmodule
